// File: rtl/ram_access_arbiter_if.sv
// Bus between the requesters, ram_access_arbiter and the work RAM.
interface ram_access_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 12,
    parameter int DW      = 16
);
    // Handshake: a requester raises req[i] with we/be/addr/wdata stable and holds
    // them until ack[i] pulses for one cycle; inputs are only sampled while idle.
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    we;
    logic [2*NUM_REQ-1:0]  be;
    logic [AW*NUM_REQ-1:0] addr;
    logic [DW*NUM_REQ-1:0] wdata;
    logic [NUM_REQ-1:0]    ack;
    logic [DW-1:0]         rdata;
    logic [NUM_REQ-1:0]    grant;
    logic [AW-1:0]         ram_addr;
    logic                  ram_we_uds_n;
    logic                  ram_we_lds_n;
    logic [DW-1:0]         ram_data;
    logic [DW-1:0]         ram_q;
    logic [1:0]            state_dbg;

    modport master (
        output req, we, be, addr, wdata, ram_q,
        input  ack, rdata, grant, ram_addr, ram_we_uds_n, ram_we_lds_n, ram_data, state_dbg
    );

    modport slave (
        input  req, we, be, addr, wdata, ram_q,
        output ack, rdata, grant, ram_addr, ram_we_uds_n, ram_we_lds_n, ram_data, state_dbg
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Shares one registered single-port 16-bit RAM between NUM_REQ requesters.
// Round-robin by default; define RAM_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module ram_access_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 12,
    parameter int DW      = 16
) (
    input logic                 clock,
    input logic                 reset_n,
    ram_access_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t             state;
    logic [IW-1:0]      last_grant;
    logic [IW-1:0]      win_q;
    logic [IW-1:0]      win_c;
    logic               we_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [DW-1:0]      rdata_q;
    logic [AW-1:0]      ram_addr_q;
    logic [DW-1:0]      ram_data_q;
    logic               uds_n_q;
    logic               lds_n_q;

    logic [1:0]    be_arr    [NUM_REQ];
    logic [AW-1:0] addr_arr  [NUM_REQ];
    logic [DW-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign be_arr[i]    = bus.be[i*2 +: 2];
        assign addr_arr[i]  = bus.addr[i*AW +: AW];
        assign wdata_arr[i] = bus.wdata[i*DW +: DW];
    end

    always_comb begin : arbitrate
`ifdef RAM_ARB_FIXED_PRIO_EN
        win_c = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[IW'(i)]) win_c = IW'(i);
        end
`else
        logic [IW-1:0] cand;
        logic          found;
        win_c = '0;
        found = 1'b0;
        cand  = last_grant;
        // Search starts just past the previous winner, wrapping at NUM_REQ.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (!found && bus.req[cand]) begin
                win_c = cand;
                found = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            win_q      <= '0;
            we_q       <= 1'b0;
            grant_q    <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            uds_n_q    <= 1'b1;
            lds_n_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        win_q          <= win_c;
                        we_q           <= bus.we[win_c];
                        grant_q[win_c] <= 1'b1;
                        ram_addr_q     <= addr_arr[win_c];
                        ram_data_q     <= wdata_arr[win_c];
                        // Strobes are registered here so they are live for exactly the ISSUE cycle.
                        uds_n_q        <= ~(bus.we[win_c] & be_arr[win_c][1]);
                        lds_n_q        <= ~(bus.we[win_c] & be_arr[win_c][0]);
`ifndef RAM_ARB_FIXED_PRIO_EN
                        last_grant     <= win_c;
`endif
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    uds_n_q      <= 1'b1;
                    lds_n_q      <= 1'b1;
                    ack_q[win_q] <= 1'b1;
                    state        <= DATA;
                end
                DATA: begin
                    ack_q   <= '0;
                    grant_q <= '0;
                    if (!we_q) rdata_q <= bus.ram_q;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM output is forwarded during the ack cycle and held afterwards.
    assign bus.rdata        = (state == DATA && !we_q) ? bus.ram_q : rdata_q;
    assign bus.ack          = ack_q;
    assign bus.grant        = grant_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_data     = ram_data_q;
    assign bus.ram_we_uds_n = uds_n_q;
    assign bus.ram_we_lds_n = lds_n_q;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural registered RAM.
module tb_ram_access_arbiter;
    localparam int NUM_REQ = 3;
    localparam int AW      = 12;
    localparam int DW      = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    ram_access_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

    ram_access_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    // Registered single-port RAM with byte strobes, read-before-write.
    always @(posedge clock) begin
        if (!bus.ram_we_uds_n) mem[bus.ram_addr][15:8] <= bus.ram_data[15:8];
        if (!bus.ram_we_lds_n) mem[bus.ram_addr][7:0]  <= bus.ram_data[7:0];
        bus.ram_q <= mem[bus.ram_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req   = '0;
        bus.we    = '0;
        bus.be    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic set_req(input int i, input logic w, input logic [1:0] b,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]            = 1'b1;
        bus.we[i]             = w;
        bus.be[i*2 +: 2]      = b;
        bus.addr[i*AW +: AW]  = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_for_ack(input int limit, output logic [NUM_REQ-1:0] seen, output int cyc);
        seen = '0;
        cyc  = 0;
        while (seen == '0 && cyc < limit) begin
            tick();
            cyc++;
            seen = bus.ack;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tests_run++; if (bus.grant !== 3'b000) begin tests_failed++; $display("FAIL reset_grant: got %b want 000", bus.grant); end
        tests_run++; if (bus.ack !== 3'b000) begin tests_failed++; $display("FAIL reset_ack: got %b want 000", bus.ack); end
        tests_run++; if (bus.rdata !== 16'h0000) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0000", bus.rdata); end
        tests_run++; if (bus.ram_addr !== 12'h000) begin tests_failed++; $display("FAIL reset_ram_addr: got %h want 000", bus.ram_addr); end
        tests_run++; if (bus.ram_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_ram_data: got %h want 0000", bus.ram_data); end
        tests_run++; if ({bus.ram_we_uds_n, bus.ram_we_lds_n} !== 2'b11) begin tests_failed++; $display("FAIL reset_strobes: got %b want 11", {bus.ram_we_uds_n, bus.ram_we_lds_n}); end
        tests_run++; if (bus.state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
        reset_n = 1'b1;
    endtask

    task automatic test_read();
        mem[12'h123] = 16'hBEEF;
        set_req(0, 1'b0, 2'b11, 12'h123, 16'h0000);
        tick();
        tests_run++; if (bus.ram_addr !== 12'h123) begin tests_failed++; $display("FAIL read_ram_addr: got %h want 123", bus.ram_addr); end
        tests_run++; if ({bus.ram_we_uds_n, bus.ram_we_lds_n} !== 2'b11) begin tests_failed++; $display("FAIL read_strobes: got %b want 11", {bus.ram_we_uds_n, bus.ram_we_lds_n}); end
        tests_run++; if (bus.grant !== 3'b001) begin tests_failed++; $display("FAIL read_grant: got %b want 001", bus.grant); end
        tests_run++; if (bus.ack !== 3'b000) begin tests_failed++; $display("FAIL read_ack_issue: got %b want 000", bus.ack); end
        tick();
        tests_run++; if (bus.ack !== 3'b001) begin tests_failed++; $display("FAIL read_ack: got %b want 001", bus.ack); end
        tests_run++; if (bus.rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL read_rdata: got %h want beef", bus.rdata); end
        idle_inputs();
        tick();
        tests_run++; if (bus.ack !== 3'b000) begin tests_failed++; $display("FAIL read_ack_clear: got %b want 000", bus.ack); end
        tests_run++; if (bus.grant !== 3'b000) begin tests_failed++; $display("FAIL read_grant_clear: got %b want 000", bus.grant); end
        tests_run++; if (bus.rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL read_rdata_hold: got %h want beef", bus.rdata); end
    endtask

    task automatic test_byte_write();
        mem[12'h010] = 16'h1234;
        set_req(1, 1'b1, 2'b01, 12'h010, 16'hA55A);
        tick();
        tests_run++; if ({bus.ram_we_uds_n, bus.ram_we_lds_n} !== 2'b10) begin tests_failed++; $display("FAIL bw_strobes: got %b want 10", {bus.ram_we_uds_n, bus.ram_we_lds_n}); end
        tests_run++; if (bus.ram_data !== 16'hA55A) begin tests_failed++; $display("FAIL bw_ram_data: got %h want a55a", bus.ram_data); end
        tests_run++; if (bus.grant !== 3'b010) begin tests_failed++; $display("FAIL bw_grant: got %b want 010", bus.grant); end
        tick();
        tests_run++; if ({bus.ram_we_uds_n, bus.ram_we_lds_n} !== 2'b11) begin tests_failed++; $display("FAIL bw_strobes_off: got %b want 11", {bus.ram_we_uds_n, bus.ram_we_lds_n}); end
        tests_run++; if (bus.ack !== 3'b010) begin tests_failed++; $display("FAIL bw_ack: got %b want 010", bus.ack); end
        tests_run++; if (mem[12'h010] !== 16'h125A) begin tests_failed++; $display("FAIL bw_mem: got %h want 125a", mem[12'h010]); end
        idle_inputs();
        tick();
        set_req(1, 1'b0, 2'b11, 12'h010, 16'h0000);
        tick();
        tick();
        tests_run++; if (bus.ack !== 3'b010) begin tests_failed++; $display("FAIL bw_readback_ack: got %b want 010", bus.ack); end
        tests_run++; if (bus.rdata !== 16'h125A) begin tests_failed++; $display("FAIL bw_readback: got %h want 125a", bus.rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        mem[12'h200] = 16'h0000;
        set_req(0, 1'b1, 2'b11, 12'h200, 16'h0F0F);
        tick();
        tests_run++; if ({bus.ram_we_uds_n, bus.ram_we_lds_n} !== 2'b00) begin tests_failed++; $display("FAIL rm_strobes_issue: got %b want 00", {bus.ram_we_uds_n, bus.ram_we_lds_n}); end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++; if ({bus.ram_we_uds_n, bus.ram_we_lds_n} !== 2'b11) begin tests_failed++; $display("FAIL rm_strobes: got %b want 11", {bus.ram_we_uds_n, bus.ram_we_lds_n}); end
        tests_run++; if (bus.grant !== 3'b000) begin tests_failed++; $display("FAIL rm_grant: got %b want 000", bus.grant); end
        tests_run++; if (bus.ack !== 3'b000) begin tests_failed++; $display("FAIL rm_ack: got %b want 000", bus.ack); end
        tests_run++; if (bus.state_dbg !== 2'd0) begin tests_failed++; $display("FAIL rm_state: got %0d want 0", bus.state_dbg); end
        idle_inputs();
        tick();
        tests_run++; if (mem[12'h200] !== 16'h0000) begin tests_failed++; $display("FAIL rm_mem: got %h want 0000", mem[12'h200]); end
        reset_n = 1'b1;
        set_req(0, 1'b0, 2'b11, 12'h001, 16'h0000);
        set_req(1, 1'b0, 2'b11, 12'h002, 16'h0000);
        set_req(2, 1'b0, 2'b11, 12'h003, 16'h0000);
        tick();
        tests_run++; if (bus.grant !== 3'b001) begin tests_failed++; $display("FAIL rm_first_grant: got %b want 001", bus.grant); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_contention();
        logic [NUM_REQ-1:0] seen;
        logic [NUM_REQ-1:0] exp_ack;
        logic [DW-1:0]      exp_data;
        int                 cyc;
        int                 who;
        mem[12'h001] = 16'h1111;
        mem[12'h002] = 16'h2222;
        mem[12'h003] = 16'h3333;
        reset_n = 1'b0;
        set_req(0, 1'b0, 2'b11, 12'h001, 16'h0000);
        set_req(1, 1'b0, 2'b11, 12'h002, 16'h0000);
        set_req(2, 1'b0, 2'b11, 12'h003, 16'h0000);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            who = 0;
`else
            who = i % 3;
`endif
            exp_ack  = 3'b001 << who;
            exp_data = 16'h1111 * 16'(who + 1);
            wait_for_ack(10, seen, cyc);
            tests_run++; if (seen !== exp_ack) begin tests_failed++; $display("FAIL cont_ack_%0d: got %b want %b", i, seen, exp_ack); end
            tests_run++; if (cyc !== ((i == 0) ? 2 : 3)) begin tests_failed++; $display("FAIL cont_spacing_%0d: got %0d want %0d", i, cyc, (i == 0) ? 2 : 3); end
            tests_run++; if (bus.rdata !== exp_data) begin tests_failed++; $display("FAIL cont_rdata_%0d: got %h want %h", i, bus.rdata, exp_data); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        mem[12'h300] = 16'h5555;
        set_req(2, 1'b1, 2'b00, 12'h300, 16'hFFFF);
        tick();
        tests_run++; if ({bus.ram_we_uds_n, bus.ram_we_lds_n} !== 2'b11) begin tests_failed++; $display("FAIL zbe_strobes: got %b want 11", {bus.ram_we_uds_n, bus.ram_we_lds_n}); end
        tests_run++; if (bus.grant !== 3'b100) begin tests_failed++; $display("FAIL zbe_grant: got %b want 100", bus.grant); end
        tick();
        tests_run++; if (bus.ack !== 3'b100) begin tests_failed++; $display("FAIL zbe_ack: got %b want 100", bus.ack); end
        idle_inputs();
        tick();
        tests_run++; if (bus.ack !== 3'b000) begin tests_failed++; $display("FAIL b2b_idle_ack: got %b want 000", bus.ack); end
        set_req(2, 1'b0, 2'b11, 12'h300, 16'h0000);
        tick();
        tests_run++; if (bus.grant !== 3'b100) begin tests_failed++; $display("FAIL b2b_grant: got %b want 100", bus.grant); end
        // req2 dropped after grant must still complete; req1 raised only while busy.
        bus.req[2] = 1'b0;
        set_req(1, 1'b0, 2'b11, 12'h010, 16'h0000);
        tick();
        tests_run++; if (bus.ack !== 3'b100) begin tests_failed++; $display("FAIL b2b_ack: got %b want 100", bus.ack); end
        tests_run++; if (bus.rdata !== 16'h5555) begin tests_failed++; $display("FAIL zbe_mem_unchanged: got %h want 5555", bus.rdata); end
        bus.req[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if ({bus.ack, bus.grant} !== 6'b000000) begin tests_failed++; $display("FAIL dropped_req_%0d: got ack %b grant %b want 000 000", i, bus.ack, bus.grant); end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
        idle_inputs();
        test_reset();
        test_read();
        test_byte_write();
        test_reset_mid();
        test_contention();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
